priority_span_decoder: RTL

Consumes the one-hot left/right pair produced by the priority encoder (highest and lowest set bit of a WIDTH-bit word). It expands the pair back into usable form: binary bit indices, the contiguous span mask between the two bits (inclusive), and the span length. It is a 2-stage valid/ready pipeline with full throughput and backpressure. It sits downstream of the encoder in the request-arbitration path.

---
 rtl/priority_span_decoder_pkg.sv | 30 +++
 rtl/priority_span_decoder_onehot_to_bin.sv | 24 ++
 rtl/priority_span_decoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/priority_span_decoder_pkg.sv
// Shared definitions for the priority span decoder: width helpers,
// span classification and the stage-1 payload carried between pipeline stages.
package priority_pkg;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int len_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int PSD_WIDTH = 16;
    localparam int PSD_IDX_W = idx_width(PSD_WIDTH);

    typedef enum logic [1:0] {
        SPAN_OK,
        SPAN_EMPTY,
        SPAN_ERR
    } span_class_t;

    typedef struct packed {
        logic [PSD_WIDTH-1:0] left;
        logic [PSD_WIDTH-1:0] right;
        logic [PSD_IDX_W-1:0] left_idx;
        logic [PSD_IDX_W-1:0] right_idx;
        span_class_t          cls;
    } s1_payload_t;

endpackage

// File: rtl/priority_span_decoder_onehot_to_bin.sv
// One-hot to binary index decoder built purely from OR-reductions;
// a malformed input simply yields the OR of the indices of its set bits.
module onehot_to_bin
    import priority_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot_i,
    output logic [IDX_W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int b = 0; b < IDX_W; b++) begin
                if (((i >> b) & 1) != 0) begin
                    bin_o[b] = bin_o[b] | onehot_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/priority_span_decoder.sv
// Expands a highest/lowest one-hot pair into indices, an inclusive span mask
// and span length through a 2-stage valid/ready pipeline.
module priority_span_decoder
    import priority_pkg::*;
#(
    parameter int WIDTH = PSD_WIDTH,
    localparam int IDX_W = idx_width(WIDTH),
    localparam int LEN_W = len_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic [WIDTH-1:0] span_mask_o,
    output logic [LEN_W-1:0] span_len_o,
    output logic             empty_o,
    output logic             err_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

    logic [IDX_W-1:0] in_left_idx;
    logic [IDX_W-1:0] in_right_idx;
    logic             in_left_oh;
    logic             in_right_oh;
    span_class_t      in_cls;

    s1_payload_t      s1_d, s1_q;
    logic             s1_valid_d, s1_valid_q;
    logic             s1_adv, s2_adv;

    logic [WIDTH:0]   left_ext, right_ext;
    logic [WIDTH-1:0] span_mask;
    logic [LEN_W-1:0] span_len;

    logic             s2_valid_d, s2_valid_q;
    logic [IDX_W-1:0] left_idx_d, left_idx_q;
    logic [IDX_W-1:0] right_idx_d, right_idx_q;
    logic [WIDTH-1:0] mask_d, mask_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic             empty_d, empty_q;
    logic             err_d, err_q;

    onehot_to_bin #(.WIDTH(WIDTH)) u_left_dec (
        .onehot_i (data_left_i),
        .bin_o    (in_left_idx)
    );

    onehot_to_bin #(.WIDTH(WIDTH)) u_right_dec (
        .onehot_i (data_right_i),
        .bin_o    (in_right_idx)
    );

    // Handshake: ready depends only on pipeline occupancy and data_ready_i.
    assign s2_adv       = !s2_valid_q || data_ready_i;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign data_ready_o = s1_adv;

    always_comb begin
        in_left_oh  = (data_left_i != '0) &&
                      ((data_left_i & (data_left_i - WIDTH'(1))) == '0);
        in_right_oh = (data_right_i != '0) &&
                      ((data_right_i & (data_right_i - WIDTH'(1))) == '0);
        in_cls = SPAN_OK;
        if ((data_left_i == '0) && (data_right_i == '0)) begin
            in_cls = SPAN_EMPTY;
        end else if (!in_left_oh || !in_right_oh) begin
            in_cls = SPAN_ERR;
        end else if (in_left_idx < in_right_idx) begin
            in_cls = SPAN_ERR;
        end
    end

    // Stage 1: capture the pair with its decoded indices and class.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = data_val_i;
            if (data_val_i) begin
                s1_d.left      = data_left_i;
                s1_d.right     = data_right_i;
                s1_d.left_idx  = in_left_idx;
                s1_d.right_idx = in_right_idx;
                s1_d.cls       = in_cls;
            end
        end
    end

    // Stage 2: the extra top bit lets a left bit at WIDTH-1 shift out cleanly.
    always_comb begin
        left_ext  = {1'b0, s1_q.left};
        right_ext = {1'b0, s1_q.right};
        span_mask = WIDTH'(((left_ext << 1) - ONE_EXT) & ~(right_ext - ONE_EXT));
        span_len  = LEN_W'(s1_q.left_idx) - LEN_W'(s1_q.right_idx) + LEN_W'(1);

        s2_valid_d  = s2_valid_q;
        left_idx_d  = left_idx_q;
        right_idx_d = right_idx_q;
        mask_d      = mask_q;
        len_d       = len_q;
        empty_d     = empty_q;
        err_d       = err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                left_idx_d  = '0;
                right_idx_d = '0;
                mask_d      = '0;
                len_d       = '0;
                empty_d     = (s1_q.cls == SPAN_EMPTY);
                err_d       = (s1_q.cls == SPAN_ERR);
                if (s1_q.cls == SPAN_OK) begin
                    left_idx_d  = s1_q.left_idx;
                    right_idx_d = s1_q.right_idx;
                    mask_d      = span_mask;
                    len_d       = span_len;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            left_idx_q  <= '0;
            right_idx_q <= '0;
            mask_q      <= '0;
            len_q       <= '0;
            empty_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            left_idx_q  <= left_idx_d;
            right_idx_q <= right_idx_d;
            mask_q      <= mask_d;
            len_q       <= len_d;
            empty_q     <= empty_d;
            err_q       <= err_d;
        end
    end

    assign data_val_o  = s2_valid_q;
    assign left_idx_o  = left_idx_q;
    assign right_idx_o = right_idx_q;
    assign span_mask_o = mask_q;
    assign span_len_o  = len_q;
    assign empty_o     = empty_q;
    assign err_o       = err_q;

endmodule
